// File: rtl/he_pkg.sv
// Shared definitions for the histogram-equalization statistics stage.
//   state_t   : controller states (INIT clears the histogram, ACCUM counts
//               pixels, SCAN builds the CDF and the LUT, DONE publishes it)
//   levels    : number of grey levels for a given pixel width
//   count_w   : width of histogram bins and of the CDF accumulator; one bit
//               more than log2(pixels per frame) so a full-frame count fits
//   lut_scale : multiplier that maps a CDF value onto the output grey range
package he_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int levels(input int width);
    return 1 << width;
  endfunction

  function automatic int count_w(input int log2_pixels);
    return log2_pixels + 1;
  endfunction

  function automatic int lut_scale(input int width);
    return levels(width) - 1;
  endfunction

endpackage

// File: rtl/he_hist_lut_if.sv
// Bus bundle of the histogram-equalization stage.
//   fifo_empty   : upstream FIFO empty flag
//   fifo_rd_en   : pop request to the upstream FIFO
//   fifo_rd_data : pixel, valid in the cycle of an accepted pop
//   lut_rd_addr  : grey level to map
//   lut_rd_data  : mapped level, one cycle after the address
//   lut_ready    : LUT holds a complete mapping
//   frame_done   : one-cycle pulse when a new LUT is complete
// master = the statistics block, slave = FIFO / remap side.
interface he_hist_lut_if #(
  parameter int WIDTH = 8
) ();

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic [WIDTH-1:0] lut_rd_addr;
  logic [WIDTH-1:0] lut_rd_data;
  logic             lut_ready;
  logic             frame_done;

  modport master (
    input  fifo_empty, fifo_rd_data, lut_rd_addr,
    output fifo_rd_en, lut_rd_data, lut_ready, frame_done
  );

  modport slave (
    output fifo_empty, fifo_rd_data, lut_rd_addr,
    input  fifo_rd_en, lut_rd_data, lut_ready, frame_done
  );

endinterface

// File: rtl/he_lut_ram.sv
// Equalization mapping memory: WIDTH bits x 2**WIDTH entries.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : single write port
//   raddr, rdata     : registered read port, one cycle latency
// Contents are never reset so a mapping survives a controller reset.
module he_lut_ram
  import he_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int LEVELS = levels(WIDTH);

  logic [WIDTH-1:0] mem [LEVELS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/he_hist_lut.sv
// Histogram-equalization statistics stage. Pops pixels from the upstream
// FIFO, builds a per-frame grey-level histogram, then at end of frame scans
// it into a CDF and writes the mapping LUT read by the remap stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : FIFO pop handshake, LUT read port, lut_ready, frame_done
module he_hist_lut
  import he_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LOG2_PIXELS = 16
) (
  input  logic          clk,
  input  logic          rst,
  he_hist_lut_if.master bus
);

  localparam int LEVELS = levels(WIDTH);
  localparam int CW     = count_w(LOG2_PIXELS);
  localparam int PW     = CW + WIDTH;
  localparam logic [PW-1:0] SCALE = PW'(lut_scale(WIDTH));

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       bin_q, bin_d;
  logic [LOG2_PIXELS-1:0] cnt_q, cnt_d;
  logic [CW-1:0]          cdf_q, cdf_d;
  logic                   ready_q, ready_d;

  logic [CW-1:0]    hist [LEVELS];
  logic             hist_we;
  logic [WIDTH-1:0] hist_waddr;
  logic [CW-1:0]    hist_wdata;

  logic             accept;
  logic             lut_we;
  logic [CW-1:0]    c;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] lut_wdata;

  // Pops are suppressed while rst is high so no pixel is lost to a reset cycle.
  assign accept         = (state_q == ACCUM) && !bus.fifo_empty && !rst;
  assign bus.fifo_rd_en = accept;
  assign bus.frame_done = (state_q == DONE) && !rst;
  assign bus.lut_ready  = ready_q;

  // Running CDF including the current bin, scaled onto the output range.
  assign c         = cdf_q + hist[bin_q];
  assign prod      = PW'(c) * SCALE;
  assign lut_wdata = WIDTH'(prod >> LOG2_PIXELS);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    cdf_d      = cdf_q;
    ready_d    = ready_q;
    hist_we    = 1'b0;
    hist_waddr = bin_q;
    hist_wdata = '0;
    lut_we     = 1'b0;
    unique case (state_q)
      INIT: begin
        hist_we = 1'b1;
        bin_d   = bin_q + 1'b1;
        if (bin_q == {WIDTH{1'b1}}) state_d = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          // Single-cycle read-modify-write, so repeated values back-to-back
          // always see the freshly written count.
          hist_we    = 1'b1;
          hist_waddr = bus.fifo_rd_data;
          hist_wdata = hist[bus.fifo_rd_data] + 1'b1;
          if (cnt_q == {LOG2_PIXELS{1'b1}}) begin
            cnt_d   = '0;
            bin_d   = '0;
            ready_d = 1'b0;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SCAN: begin
        // Clearing each bin as it is consumed removes the need for a
        // separate clear pass before the next frame.
        hist_we = 1'b1;
        cdf_d   = c;
        lut_we  = 1'b1;
        bin_d   = bin_q + 1'b1;
        if (bin_q == {WIDTH{1'b1}}) state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        cdf_d   = '0;
        state_d = ACCUM;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      bin_q   <= '0;
      cnt_q   <= '0;
      cdf_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      cdf_q   <= cdf_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist[hist_waddr] <= hist_wdata;
  end

  he_lut_ram #(
    .WIDTH(WIDTH)
  ) u_lut (
    .clk  (clk),
    .rst  (rst),
    .we   (lut_we && !rst),
    .waddr(bin_q),
    .wdata(lut_wdata),
    .raddr(bus.lut_rd_addr),
    .rdata(bus.lut_rd_data)
  );

endmodule

// File: tb/tb_he_hist_lut.sv
// Bench for he_hist_lut (WIDTH=8, 16 pixels per frame). A FIFO driver feeds
// pixel queues, a reference model derives each LUT from the frame's pixel
// counts, and a monitor compares frame_done timing and LUT reads against
// expectations queued by the stimulus.
module tb_he_hist_lut;

  localparam int W    = 8;
  localparam int L2   = 4;
  localparam int NPIX = 16;
  localparam int LV   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  he_hist_lut_if #(.WIDTH(W)) bus ();

  he_hist_lut #(
    .WIDTH      (W),
    .LOG2_PIXELS(L2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int pix_q[$];
  int exp_done_q[$];
  int exp_lut_q[$];
  int model_lut[LV];
  bit stall_en = 1'b0;
  int frame_cnt = 0;
  int viol = 0;
  int done_count = 0;
  bit rd_issue = 1'b0;
  bit rd_issue_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: presents the head pixel unless empty or randomly stalled.
  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      if (pix_q.size() > 0 && !(stall_en && $urandom_range(0, 1) == 1)) begin
        bus.fifo_empty   = 1'b0;
        bus.fifo_rd_data = W'(pix_q[0]);
      end else begin
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = W'($urandom_range(0, LV - 1));
      end
      #1;
      if (bus.fifo_rd_en) begin
        if (bus.fifo_empty) viol++;
        else begin
          void'(pix_q.pop_front());
          frame_cnt++;
          if (frame_cnt == NPIX) begin
            exp_done_q.push_back(cyc + LV + 1);
            frame_cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: LUT read data one cycle after an issued address; frame_done cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd_issue_prev)
        check("lut_rd_data", int'(bus.lut_rd_data),
              exp_lut_q.size() > 0 ? exp_lut_q.pop_front() : -1);
      rd_issue_prev = rd_issue;
      if (bus.frame_done) begin
        done_count++;
        check("frame_done_cycle", cyc,
              exp_done_q.size() > 0 ? exp_done_q.pop_front() : -1);
      end
    end
  end

  // Reference: mapped level = floor(pixels_at_or_below * 255 / pixels_per_frame).
  task automatic load_frame(input int vals[$]);
    int hcount[LV];
    int cum;
    foreach (hcount[i]) hcount[i] = 0;
    foreach (vals[i]) hcount[vals[i]]++;
    cum = 0;
    for (int l = 0; l < LV; l++) begin
      cum += hcount[l];
      model_lut[l] = (cum * (LV - 1)) / NPIX;
    end
    foreach (vals[i]) pix_q.push_back(vals[i]);
  endtask

  task automatic wait_done(input string name);
    int start;
    int n;
    int bad;
    int e;
    start = done_count;
    n = 0;
    bad = 0;
    while (done_count == start && n < 3000) begin
      @(negedge clk);
      #3;
      e = exp_done_q.size() > 0 ? exp_done_q[0] : -1;
      if (e > 0 && cyc > e - LV - 1 && cyc <= e && bus.lut_ready) bad++;
      n++;
    end
    check({name, "_done_pulses"}, done_count - start, 1);
    check({name, "_ready_low_in_scan"}, bad, 0);
    @(negedge clk);
    #3;
    check({name, "_lut_ready"}, int'(bus.lut_ready), 1);
  endtask

  task automatic read_one(input int addr);
    @(negedge clk);
    bus.lut_rd_addr = W'(addr);
    rd_issue = 1'b1;
    exp_lut_q.push_back(model_lut[addr]);
  endtask

  task automatic read_end();
    @(negedge clk);
    rd_issue = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int l = 0; l < LV; l++) read_one(l);
    read_end();
  endtask

  // Called on a falling edge; rst is seen by two rising edges.
  task automatic reset_assert();
    rst = 1'b1;
    pix_q.delete();
    exp_done_q.delete();
    frame_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_check_init(input string name);
    int n;
    int bad;
    rst = 1'b0;
    n = 0;
    bad = 0;
    #3;
    while (!bus.fifo_rd_en && n < 1000) begin
      if (bus.lut_ready || bus.frame_done) bad++;
      n++;
      @(negedge clk);
      #3;
    end
    check({name, "_init_cycles"}, n, LV);
    check({name, "_ready_done_low"}, bad, 0);
  endtask

  initial begin
    int fr[$];
    int n;
    int target;
    bus.lut_rd_addr = '0;
    @(negedge clk);
    reset_assert();

    // Tests 1+2: INIT length after reset, then a frame of 100s.
    fr.delete();
    repeat (NPIX) fr.push_back(100);
    load_frame(fr);
    release_check_init("t1");
    wait_done("t2");
    read_all();

    // Test 3: one pixel each of 0..15.
    fr.delete();
    for (int i = 0; i < NPIX; i++) fr.push_back(i);
    load_frame(fr);
    wait_done("t3");
    read_all();

    // Test 4: same frame with random FIFO stalls, then a random stalled frame.
    stall_en = 1'b1;
    load_frame(fr);
    wait_done("t4");
    read_all();
    fr.delete();
    repeat (NPIX) fr.push_back(int'($urandom_range(0, LV - 1)));
    load_frame(fr);
    wait_done("t4r");
    read_all();
    stall_en = 1'b0;

    // Test 5: reset during SCAN bin 40, then a frame of 3s.
    fr.delete();
    repeat (NPIX) fr.push_back(int'($urandom_range(0, LV - 1)));
    load_frame(fr);
    n = 0;
    while (exp_done_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_frame_accepted", exp_done_q.size(), 1);
    target = exp_done_q.size() > 0 ? exp_done_q[0] - LV - 1 + 41 : cyc;
    @(negedge clk);
    while (cyc < target) @(negedge clk);
    reset_assert();
    #3;
    check("t5_ready_after_rst", int'(bus.lut_ready), 0);
    fr.delete();
    repeat (NPIX) fr.push_back(3);
    load_frame(fr);
    release_check_init("t5");
    wait_done("t5");
    read_all();

    // Test 6: consecutive frames, read address 150 after each.
    fr.delete();
    repeat (NPIX) fr.push_back(100);
    load_frame(fr);
    wait_done("t6a");
    read_one(150);
    read_end();
    fr.delete();
    repeat (NPIX) fr.push_back(200);
    load_frame(fr);
    wait_done("t6b");
    read_one(150);
    read_end();

    repeat (3) @(negedge clk);
    check("pop_while_empty", viol, 0);
    check("pending_frame_done", exp_done_q.size(), 0);
    check("pending_lut_reads", exp_lut_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
